// File: rtl/register_bus_sequencer.sv
// Register bus sequencer: arbitrates the configuration register bus between a
// host and an internal write sequencer. On a configuration request it waits for
// the host to go idle, then writes the baud divisor (low byte, high byte) and,
// only if the frame fields change, the frame register. Unless the frame write
// was skipped, it then waits for the UART to report completion.
//
// Optional feature: define CFG_TIMEOUT_EN to bound the wait on config_done_i to
// TIMEOUT_CYCLES cycles and report an expired wait on cfg_error_o.
module register_bus_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // Configuration request side
  input  logic        cfg_req_i,
  input  logic [15:0] cfg_divisor_i,
  input  logic [1:0]  cfg_data_width_i,
  input  logic [1:0]  cfg_parity_mode_i,
  input  logic [1:0]  cfg_stop_bits_i,
  output logic        cfg_ack_o,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  // Host bus side
  input  logic        host_read_i,
  input  logic        host_write_i,
  input  logic [2:0]  host_address_i,
  input  logic [7:0]  host_wdata_i,
  output logic        host_grant_o,
  // Configuration register file side
  output logic        reg_read_o,
  output logic        reg_write_o,
  output logic [2:0]  reg_address_o,
  output logic [7:0]  reg_wdata_o,
  // UART configuration status
  input  logic        config_done_i
);

  // Register file address codes
  localparam logic [2:0] CTR_ADDR  = 3'h0;
  localparam logic [2:0] STR_ADDR  = 3'h1;
  localparam logic [2:0] LDVR_ADDR = 3'h2;
  localparam logic [2:0] UDVR_ADDR = 3'h3;

  // Power-on frame settings of the UART: 8 data bits, no parity, 1 stop bit
  localparam logic [1:0] STD_DATA_WIDTH  = 2'b11;
  localparam logic [1:0] STD_PARITY_MODE = 2'b00;
  localparam logic [1:0] STD_STOP_BITS   = 2'b00;
  localparam logic [5:0] STD_FRAME = {STD_DATA_WIDTH, STD_PARITY_MODE, STD_STOP_BITS};

  // The timeout compare needs a count range of at least 0..1
  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWaitBus,
    StWrLdvr,
    StWrUdvr,
    StWrStr,
    StWaitCdone,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] divisor_q, divisor_d;
  logic [5:0]  frame_q, frame_d;    // {DWID, PMID, SBID} captured with the request
  logic [5:0]  shadow_q, shadow_d;  // last frame value written to the UART
  logic        cdone_q;

  logic        cdone_rise;
  logic        seq_write;
  logic [2:0]  seq_address;
  logic [7:0]  seq_wdata;
  logic        timeout_hit;

  assign cdone_rise = config_done_i & ~cdone_q;

`ifdef CFG_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] timer_q, timer_d;

  assign timeout_hit = (timer_q == CntLast);

  // Wait-cycle counter: cleared on the way into WAIT_CDONE, counts while there
  always_comb begin
    timer_d = timer_q;
    if (state_q == StWrStr) begin
      timer_d = '0;
    end else if (state_q == StWaitCdone) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Wait-cycle counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Sequencer next-state, operand capture and pulse outputs
  always_comb begin
    state_d      = state_q;
    divisor_d    = divisor_q;
    frame_d      = frame_q;
    shadow_d     = shadow_q;
    cfg_ack_o    = 1'b0;
    cfg_done_o   = 1'b0;
    cfg_error_o  = 1'b0;
    host_grant_o = 1'b1;
    seq_write    = 1'b0;
    seq_address  = CTR_ADDR;
    seq_wdata    = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (cfg_req_i) begin
          divisor_d = cfg_divisor_i;
          frame_d   = {cfg_data_width_i, cfg_parity_mode_i, cfg_stop_bits_i};
          cfg_ack_o = 1'b1;
          state_d   = StWaitBus;
        end
      end

      StWaitBus: begin
        // The host keeps the bus until it has no access in flight
        if (!host_read_i && !host_write_i) begin
          state_d = StWrLdvr;
        end
      end

      StWrLdvr: begin
        host_grant_o = 1'b0;
        seq_write    = 1'b1;
        seq_address  = LDVR_ADDR;
        seq_wdata    = divisor_q[7:0];
        state_d      = StWrUdvr;
      end

      StWrUdvr: begin
        host_grant_o = 1'b0;
        seq_write    = 1'b1;
        seq_address  = UDVR_ADDR;
        seq_wdata    = divisor_q[15:8];
        // An unchanged frame needs no STR write and no reconfiguration wait
        state_d      = (frame_q == shadow_q) ? StDone : StWrStr;
      end

      StWrStr: begin
        host_grant_o = 1'b0;
        seq_write    = 1'b1;
        seq_address  = STR_ADDR;
        seq_wdata    = {2'b00, frame_q};
        shadow_d     = frame_q;
        state_d      = StWaitCdone;
      end

      StWaitCdone: begin
        if (cdone_rise) begin
          state_d = StDone;
        end else if (timeout_hit) begin
          cfg_error_o = 1'b1;
          state_d     = StIdle;
        end
      end

      StDone: begin
        cfg_done_o = 1'b1;
        state_d    = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register bus mux: host passes straight through while it holds the grant
  always_comb begin
    reg_read_o    = 1'b0;
    reg_write_o   = seq_write;
    reg_address_o = seq_address;
    reg_wdata_o   = seq_wdata;
    if (host_grant_o) begin
      reg_read_o    = host_read_i;
      reg_write_o   = host_write_i;
      reg_address_o = host_address_i;
      reg_wdata_o   = host_wdata_i;
    end
  end

  // Sequencer state, captured operands, frame shadow and config_done_i history
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      divisor_q <= 16'h0000;
      frame_q   <= 6'h00;
      shadow_q  <= STD_FRAME;
      cdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      frame_q   <= frame_d;
      shadow_q  <= shadow_d;
      cdone_q   <= config_done_i;
    end
  end

endmodule

// File: doc/register_bus_sequencer.md
REGISTER_BUS_SEQUENCER -- requirements
Module: register_bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, config_done_i wait limit in clock cycles (used only under CFG_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-003 clk_i  input  1  clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 cfg_req_i  input  1  configuration request, level; sampled only in IDLE.
REQ-006 cfg_divisor_i  input  16  requested baud divisor.
REQ-007 cfg_data_width_i, cfg_parity_mode_i, cfg_stop_bits_i  input  2 each  requested frame fields.
REQ-008 cfg_ack_o  output  1  one-cycle pulse: request accepted and operands captured.
REQ-009 cfg_done_o  output  1  one-cycle pulse: sequence completed.
REQ-010 cfg_error_o  output  1  one-cycle pulse: config_done_i wait timed out; constant 0 without CFG_TIMEOUT_EN.
REQ-011 host_read_i, host_write_i  input  1 each  host bus strobes.
REQ-012 host_address_i  input  3  host register address.
REQ-013 host_wdata_i  input  8  host write data.
REQ-014 host_grant_o  output  1  1 = host owns the register bus.
REQ-015 reg_read_o, reg_write_o  output  1 each  strobes to the configuration register file.
REQ-016 reg_address_o  output  3  register address, using the registers_pkg codes.
REQ-017 reg_wdata_o  output  8  register write data.
REQ-018 config_done_i  input  1  CTR CDONE level from the UART configuration process.

Function
REQ-019 SHALL implement states IDLE, WAIT_BUS, WR_LDVR, WR_UDVR, WR_STR, WAIT_CDONE and DONE.
REQ-020 IDLE: when cfg_req_i=1, SHALL capture divisor and frame fields, pulse cfg_ack_o in the same cycle, and go to WAIT_BUS.
REQ-021 WAIT_BUS: if host_read_i=0 and host_write_i=0, SHALL drop host_grant_o on the next edge and enter WR_LDVR; otherwise it SHALL remain in WAIT_BUS.
REQ-022 host_grant_o=1: reg_* SHALL equal host_* combinationally, with zero latency.
REQ-023 host_grant_o=0: host strobes SHALL NOT be forwarded, and the host holds its access until grant returns.
REQ-024 WR_LDVR, WR_UDVR and WR_STR SHALL each last exactly one cycle, be consecutive, and assert reg_write_o=1 with reg_read_o=0.
REQ-025 Write data per state: WR_LDVR sends LDVR_ADDR with divisor[7:0]; WR_UDVR sends UDVR_ADDR with divisor[15:8]; WR_STR sends STR_ADDR with {2'b00, DWID, PMID, SBID}.
REQ-026 Shadow frame register: reset value is {STD_DATA_WIDTH, STD_PARITY_MODE, STD_STOP_BITS}; it SHALL be updated on each WR_STR cycle.
REQ-027 After WR_UDVR, if the captured frame fields equal the shadow, SHALL skip WR_STR and go to DONE; otherwise it SHALL go to WR_STR.
REQ-028 After WR_STR, SHALL go to WAIT_CDONE and set host_grant_o=1.
REQ-029 WAIT_CDONE: SHALL exit to DONE on the first rising edge of config_done_i, detected from a registered copy of config_done_i; a level already high on entry SHALL NOT count.
REQ-030 DONE: SHALL pulse cfg_done_o for one cycle, set host_grant_o=1, and return to IDLE.
REQ-031 cfg_req_i asserted in any state other than IDLE SHALL be ignored, with no ack pulse and no queueing.
REQ-032 A new request SHALL be accepted at the earliest in the cycle after DONE.
REQ-033 When no sequence is active, reg_read_o and reg_write_o SHALL be 0, except when forwarding host strobes.

Reset
REQ-034 On rst_i=1, state SHALL become IDLE and host_grant_o SHALL be 1.
REQ-035 On rst_i=1, cfg_ack_o, cfg_done_o and cfg_error_o SHALL be 0, and captured operands SHALL be 0.
REQ-036 On rst_i=1, the shadow SHALL return to the standard values, and the timeout counter and registered config_done_i SHALL be 0.
REQ-037 Reset during WR_* SHALL abort the burst immediately with no further sequencer writes; a partial divisor write is acceptable.

Configuration
REQ-038 With CFG_TIMEOUT_EN defined: a counter SHALL clear on entry to WAIT_CDONE and increment each cycle there.
REQ-039 With CFG_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES-1 with no config_done_i rising edge, SHALL pulse cfg_error_o and go to IDLE without pulsing cfg_done_o, leaving the shadow updated.
REQ-040 With CFG_TIMEOUT_EN undefined: no counter SHALL exist, WAIT_CDONE SHALL wait indefinitely, and cfg_error_o SHALL be tied to 0.

Verification
REQ-041 Idle host, request with divisor=16'h0145, fields 2'b11/2'b01/2'b00 differing from the shadow -> ack, then writes LDVR=8'h45, UDVR=8'h01 and STR=8'h34 on consecutive cycles; a config_done_i 0->1 then produces cfg_done_o.
REQ-042 Request with fields equal to the standard values after reset -> only the LDVR and UDVR writes occur, then cfg_done_o follows 1 cycle after WR_UDVR.
REQ-043 host_write_i held high for 5 cycles during WAIT_BUS -> no sequencer write appears; the burst starts 1 cycle after the host strobe drops.
REQ-044 cfg_req_i held high through the whole sequence -> exactly one cfg_ack_o and one cfg_done_o per sequence; the next ack comes one cycle after DONE.
REQ-045 CFG_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, config_done_i held 0 -> cfg_error_o pulses 8 cycles after WAIT_CDONE entry, no cfg_done_o occurs, and the state returns to IDLE.
REQ-046 rst_i asserted in WR_UDVR -> the same cycle shows state IDLE, host_grant_o=1 and reg_write_o=host_write_i.
